// File: rtl/axi_rd_arb_pkg.sv
// rtl/axi_rd_arb_pkg.sv - shared encodings for the AXI read-channel arbiter
//
// Purpose: FSM state encoding, requester AXI ids and AXI constants used by
//          axi_rd_arbiter and rr_grant2.
// Ports:   none (package).

package axi_rd_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_ADDR = 2'd1,
      ARB_DATA = 2'd2
   } arb_state_e;

   // AR/R id carried by each requester's transaction
   localparam int ARB_ID_INST = 0;
   localparam int ARB_ID_DATA = 1;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   // r_resp bit that flags SLVERR/DECERR
   localparam int         AXI_RESP_SLVERR = 1;

endpackage

// File: rtl/rr_grant2.sv
// rtl/rr_grant2.sv - two-input one-hot grant, fixed priority or round robin
//
// Purpose: picks one of two requesters. Build macro AXI_RD_ARB_RR_EN selects
//          two-way round robin; otherwise fixed priority, req_i[1] over req_i[0].
// Ports:
//   clk        in   core clock (round robin build only)
//   rst_n      in   asynchronous active-low reset (round robin build only)
//   req_i      in   [1:0] request vector, bit 1 = data load, bit 0 = fetch
//   advance_i  in   a grant was accepted this cycle
//   gnt_o      out  [1:0] one-hot grant, zero when nothing requests

module rr_grant2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_i,
   input  logic       advance_i,
   output logic [1:0] gnt_o
);

`ifdef AXI_RD_ARB_RR_EN
   // 1 = requester 1 was granted last; resets to 1 so requester 0 wins the first tie
   logic last_grant_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 1'b1;
      end else if (advance_i) begin
         last_grant_q <= gnt_o[1];
      end
   end

   always_comb begin
      gnt_o = req_i;
      if (req_i == 2'b11) begin
         gnt_o = last_grant_q ? 2'b01 : 2'b10;
      end
   end
`else
   logic unused_rr;
   assign unused_rr = ^{clk, rst_n, advance_i};

   always_comb begin
      gnt_o = 2'b00;
      if (req_i[1]) begin
         gnt_o = 2'b10;
      end else if (req_i[0]) begin
         gnt_o = 2'b01;
      end
   end
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - shares one AXI read channel between fetch and load
//
// Purpose: arbitrates instruction fetch (m0) and data load (m1) onto a single
//          AXI AR/R channel. One outstanding transaction, single-beat bursts.
//          AXI_RD_ARB_RR_EN selects round-robin arbitration (default m1 > m0).
// Ports:
//   clk, rst_n              core clock, asynchronous active-low reset
//   mN_req_valid_i/ready_o  request handshake, ready is combinational in IDLE
//   mN_req_addr_i/size_i    request byte address and AXI size
//   mN_rsp_valid_o          one-cycle response pulse
//   mN_rsp_data_o/err_o     response data and error, valid with rsp_valid
//   ar_*                    AXI read address channel (len 0, burst INCR)
//   r_*                     AXI read data channel
//   busy_o                  transaction in progress

module axi_rd_arbiter
   import axi_rd_arb_pkg::*;
#(
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_ID_WIDTH   = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      m0_req_valid_i,
   output logic                      m0_req_ready_o,
   input  logic [AXI_ADDR_WIDTH-1:0] m0_req_addr_i,
   input  logic [2:0]                m0_req_size_i,
   output logic                      m0_rsp_valid_o,
   output logic [AXI_DATA_WIDTH-1:0] m0_rsp_data_o,
   output logic                      m0_rsp_err_o,
   input  logic                      m1_req_valid_i,
   output logic                      m1_req_ready_o,
   input  logic [AXI_ADDR_WIDTH-1:0] m1_req_addr_i,
   input  logic [2:0]                m1_req_size_i,
   output logic                      m1_rsp_valid_o,
   output logic [AXI_DATA_WIDTH-1:0] m1_rsp_data_o,
   output logic                      m1_rsp_err_o,
   output logic                      ar_valid_o,
   input  logic                      ar_ready_i,
   output logic [AXI_ADDR_WIDTH-1:0] ar_addr_o,
   output logic [AXI_ID_WIDTH-1:0]   ar_id_o,
   output logic [2:0]                ar_size_o,
   output logic [7:0]                ar_len_o,
   output logic [1:0]                ar_burst_o,
   input  logic                      r_valid_i,
   output logic                      r_ready_o,
   input  logic [AXI_DATA_WIDTH-1:0] r_data_i,
   input  logic [1:0]                r_resp_i,
   input  logic                      r_last_i,
   input  logic [AXI_ID_WIDTH-1:0]   r_id_i,
   output logic                      busy_o
);

   localparam logic [AXI_ID_WIDTH-1:0] ID_INST = AXI_ID_WIDTH'(ARB_ID_INST);
   localparam logic [AXI_ID_WIDTH-1:0] ID_DATA = AXI_ID_WIDTH'(ARB_ID_DATA);

   arb_state_e                state_q, state_d;
   logic [1:0]                req;
   logic [1:0]                gnt;
   logic                      grant_fire;
   logic                      last_beat;
   logic                      ar_valid_q;
   logic [AXI_ADDR_WIDTH-1:0] ar_addr_q;
   logic [AXI_ID_WIDTH-1:0]   ar_id_q;
   logic [2:0]                ar_size_q;
   logic [1:0]                rsp_valid_q;
   logic [AXI_DATA_WIDTH-1:0] rsp_data_q;
   logic                      rsp_err_q;
   logic                      unused_resp;

   // r_resp bit 0 only distinguishes OKAY/EXOKAY, which carry no error
   assign unused_resp = ^r_resp_i;

   assign req = {m1_req_valid_i, m0_req_valid_i};

   rr_grant2 u_grant (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (req),
      .advance_i (grant_fire),
      .gnt_o     (gnt)
   );

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      grant_fire     = 1'b0;
      last_beat      = 1'b0;
      r_ready_o      = 1'b0;
      m0_req_ready_o = 1'b0;
      m1_req_ready_o = 1'b0;
      unique case (state_q)
         ARB_IDLE: begin
            if (|req) begin
               grant_fire     = 1'b1;
               m0_req_ready_o = gnt[0];
               m1_req_ready_o = gnt[1];
               state_d        = ARB_ADDR;
            end
         end
         ARB_ADDR: begin
            if (ar_ready_i) begin
               state_d = ARB_DATA;
            end
         end
         ARB_DATA: begin
            r_ready_o = 1'b1;
            // non-last beats are accepted and dropped; only the last one completes
            if (r_valid_i && r_last_i) begin
               last_beat = 1'b1;
               state_d   = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // ---------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ar_valid_q  <= 1'b0;
         ar_addr_q   <= '0;
         ar_id_q     <= '0;
         ar_size_q   <= 3'd0;
         rsp_valid_q <= 2'b00;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         rsp_valid_q <= 2'b00;
         if (grant_fire) begin
            ar_valid_q <= 1'b1;
            ar_addr_q  <= gnt[1] ? m1_req_addr_i : m0_req_addr_i;
            ar_size_q  <= gnt[1] ? m1_req_size_i : m0_req_size_i;
            ar_id_q    <= gnt[1] ? ID_DATA : ID_INST;
         end else if (ar_valid_q && ar_ready_i) begin
            ar_valid_q <= 1'b0;
         end
         if (last_beat) begin
            rsp_data_q  <= r_data_i;
            rsp_err_q   <= r_resp_i[AXI_RESP_SLVERR] | (r_id_i != ar_id_q);
            rsp_valid_q <= {ar_id_q == ID_DATA, ar_id_q != ID_DATA};
         end
      end
   end

   assign ar_valid_o = ar_valid_q;
   assign ar_addr_o  = ar_addr_q;
   assign ar_id_o    = ar_id_q;
   assign ar_size_o  = ar_size_q;
   assign ar_len_o   = 8'd0;
   assign ar_burst_o = AXI_BURST_INCR;

   assign m0_rsp_valid_o = rsp_valid_q[0];
   assign m1_rsp_valid_o = rsp_valid_q[1];
   assign m0_rsp_data_o  = rsp_data_q;
   assign m1_rsp_data_o  = rsp_data_q;
   assign m0_rsp_err_o   = rsp_err_q & rsp_valid_q[0];
   assign m1_rsp_err_o   = rsp_err_q & rsp_valid_q[1];

   assign busy_o = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - self-checking bench for axi_rd_arbiter

module tb_axi_rd_arbiter;

   logic        clk;
   logic        rst_n;
   logic        m0_req_valid, m0_req_ready, m0_rsp_valid, m0_rsp_err;
   logic [31:0] m0_req_addr;
   logic [2:0]  m0_req_size;
   logic [63:0] m0_rsp_data;
   logic        m1_req_valid, m1_req_ready, m1_rsp_valid, m1_rsp_err;
   logic [31:0] m1_req_addr;
   logic [2:0]  m1_req_size;
   logic [63:0] m1_rsp_data;
   logic        ar_valid, ar_ready;
   logic [31:0] ar_addr;
   logic [3:0]  ar_id;
   logic [2:0]  ar_size;
   logic [7:0]  ar_len;
   logic [1:0]  ar_burst;
   logic        r_valid, r_ready, r_last;
   logic [63:0] r_data;
   logic [1:0]  r_resp;
   logic [3:0]  r_id;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   axi_rd_arbiter dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .m0_req_valid_i (m0_req_valid),
      .m0_req_ready_o (m0_req_ready),
      .m0_req_addr_i  (m0_req_addr),
      .m0_req_size_i  (m0_req_size),
      .m0_rsp_valid_o (m0_rsp_valid),
      .m0_rsp_data_o  (m0_rsp_data),
      .m0_rsp_err_o   (m0_rsp_err),
      .m1_req_valid_i (m1_req_valid),
      .m1_req_ready_o (m1_req_ready),
      .m1_req_addr_i  (m1_req_addr),
      .m1_req_size_i  (m1_req_size),
      .m1_rsp_valid_o (m1_rsp_valid),
      .m1_rsp_data_o  (m1_rsp_data),
      .m1_rsp_err_o   (m1_rsp_err),
      .ar_valid_o     (ar_valid),
      .ar_ready_i     (ar_ready),
      .ar_addr_o      (ar_addr),
      .ar_id_o        (ar_id),
      .ar_size_o      (ar_size),
      .ar_len_o       (ar_len),
      .ar_burst_o     (ar_burst),
      .r_valid_i      (r_valid),
      .r_ready_o      (r_ready),
      .r_data_i       (r_data),
      .r_resp_i       (r_resp),
      .r_last_i       (r_last),
      .r_id_i         (r_id),
      .busy_o         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          m;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [1:0]  resp;
      logic [3:0]  rid;
      logic [63:0] data;
      bit          nonlast;
      int          stall;
      bit          exp_err;
   } vec_t;

   vec_t vecs[7];
   vec_t tie_v[2];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic rdy(input int m);
      return (m == 1) ? m1_req_ready : m0_req_ready;
   endfunction

   function automatic logic rv(input int m);
      return (m == 1) ? m1_rsp_valid : m0_rsp_valid;
   endfunction

   function automatic logic rerr(input int m);
      return (m == 1) ? m1_rsp_err : m0_rsp_err;
   endfunction

   function automatic logic [63:0] rdata(input int m);
      return (m == 1) ? m1_rsp_data : m0_rsp_data;
   endfunction

   task automatic set_req(input int m, input logic v, input logic [31:0] a, input logic [2:0] s);
      if (m == 1) begin
         m1_req_valid = v; m1_req_addr = a; m1_req_size = s;
      end else begin
         m0_req_valid = v; m0_req_addr = a; m0_req_size = s;
      end
   endtask

   // Starts in the cycle after the grant (c1), ends in the response cycle (c3).
   task automatic finish_txn(input vec_t v);
      chk("ar_valid_c1", ar_valid, 1);
      chk("ar_addr", ar_addr, v.addr);
      chk("ar_id", ar_id, v.m);
      chk("ar_size", ar_size, v.size);
      chk("ar_len", ar_len, 0);
      chk("ar_burst", ar_burst, 2'b01);
      chk("busy_c1", busy, 1);
      for (int i = 0; i < v.stall; i++) begin
         r_valid = 1'b1; r_last = 1'b1; r_data = 64'hBAD0_BAD0_BAD0_BAD0;
         #1;
         chk("stall_r_ready", r_ready, 0);
         chk("stall_ar_valid", ar_valid, 1);
         chk("stall_ar_addr", ar_addr, v.addr);
         tick();
      end
      r_valid = 1'b0; r_last = 1'b0;
      ar_ready = 1'b1;
      tick();
      ar_ready = 1'b0;
      #1;
      chk("ar_valid_c2", ar_valid, 0);
      chk("r_ready_c2", r_ready, 1);
      if (v.nonlast) begin
         r_valid = 1'b1; r_last = 1'b0; r_data = ~v.data; r_resp = 2'b00; r_id = 4'(v.m);
         tick();
         chk("nonlast_no_rsp", rv(v.m), 0);
      end
      r_valid = 1'b1; r_last = 1'b1; r_data = v.data; r_resp = v.resp; r_id = v.rid;
      tick();
      r_valid = 1'b0; r_last = 1'b0;
      #1;
      chk("rsp_valid_c3", rv(v.m), 1);
      chk("rsp_other_quiet", rv(1 - v.m), 0);
      chk("rsp_data", rdata(v.m), v.data);
      chk("rsp_err", rerr(v.m), v.exp_err);
      chk("busy_c3", busy, 0);
   endtask

   task automatic run_vec(input vec_t v);
      set_req(v.m, 1'b1, v.addr, v.size);
      #1;
      chk("req_ready_grant", rdy(v.m), 1);
      chk("req_ready_other", rdy(1 - v.m), 0);
      tick();
      set_req(v.m, 1'b0, 32'h0, 3'd0);
      finish_txn(v);
      tick();
      chk("rsp_pulse_single", rv(v.m), 0);
   endtask

   int w;

   initial begin
      rst_n = 1'b0;
      m0_req_valid = 1'b0; m0_req_addr = '0; m0_req_size = '0;
      m1_req_valid = 1'b0; m1_req_addr = '0; m1_req_size = '0;
      ar_ready = 1'b0;
      r_valid = 1'b0; r_data = '0; r_resp = '0; r_last = 1'b0; r_id = '0;

      //           m  addr           size  resp   rid   data                    nl  stall err
      vecs[0] = '{0, 32'h8000_0000, 3'd3, 2'b00, 4'd0, 64'h1122334455667788, 0,  0,    0};
      vecs[1] = '{1, 32'h0000_1008, 3'd2, 2'b00, 4'd1, 64'hCAFE_F00D_1234_5678, 0, 0,  0};
      vecs[2] = '{1, 32'h0000_0010, 3'd3, 2'b10, 4'd1, 64'h0000_0000_0000_0010, 0, 0,  1};
      vecs[3] = '{1, 32'h0000_0020, 3'd3, 2'b00, 4'd3, 64'h0000_0000_0000_0020, 0, 0,  1};
      vecs[4] = '{0, 32'h0000_0040, 3'd1, 2'b01, 4'd0, 64'h0000_0000_0000_0040, 0, 0,  0};
      vecs[5] = '{0, 32'h0000_0080, 3'd3, 2'b00, 4'd0, 64'hDEAD_BEEF_0BAD_F00D, 1, 0,  0};
      vecs[6] = '{0, 32'hA5A5_0000, 3'd2, 2'b00, 4'd0, 64'h5555_AAAA_5555_AAAA, 0, 5,  0};
      tie_v[0] = '{0, 32'h0000_0100, 3'd3, 2'b00, 4'd0, 64'h0101_0101_0101_0101, 0, 0, 0};
      tie_v[1] = '{1, 32'h0000_0200, 3'd3, 2'b00, 4'd1, 64'h0202_0202_0202_0202, 0, 0, 0};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_ar_valid", ar_valid, 0);
      chk("rst_r_ready", r_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_m0_ready", m0_req_ready, 0);
      chk("rst_m1_ready", m1_req_ready, 0);
      chk("rst_m0_rsp", m0_rsp_valid, 0);
      chk("rst_m1_rsp", m1_rsp_valid, 0);
      chk("rst_ar_addr", ar_addr, 0);
      chk("rst_ar_id", ar_id, 0);
      chk("rst_rsp_data", m0_rsp_data, 0);
      rst_n = 1'b1;
      tick();

      // simultaneous requests: loser keeps waiting and is granted in the rsp cycle
`ifdef AXI_RD_ARB_RR_EN
      w = 0;
`else
      w = 1;
`endif
      set_req(0, 1'b1, tie_v[0].addr, tie_v[0].size);
      set_req(1, 1'b1, tie_v[1].addr, tie_v[1].size);
      #1;
      chk("tie_winner_ready", rdy(w), 1);
      chk("tie_loser_ready", rdy(1 - w), 0);
      tick();
      set_req(w, 1'b0, 32'h0, 3'd0);
      chk("tie_loser_wait_c1", rdy(1 - w), 0);
      finish_txn(tie_v[w]);
      chk("tie_loser_grant_c3", rdy(1 - w), 1);
      tick();
      set_req(1 - w, 1'b0, 32'h0, 3'd0);
      finish_txn(tie_v[1 - w]);
      tick();
      chk("tie_no_extra_rsp", m0_rsp_valid | m1_rsp_valid, 0);

      for (int i = 0; i < 7; i++) begin
         run_vec(vecs[i]);
      end

      // reset while in DATA with a last beat presented
      set_req(1, 1'b1, 32'h0000_0300, 3'd3);
      tick();
      set_req(1, 1'b0, 32'h0, 3'd0);
      ar_ready = 1'b1;
      tick();
      ar_ready = 1'b0;
      #1;
      chk("pre_rst_in_data", r_ready, 1);
      r_valid = 1'b1; r_last = 1'b1; r_data = 64'hFFFF_0000_FFFF_0000; r_id = 4'd1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_r_ready", r_ready, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ar_valid", ar_valid, 0);
      chk("mid_rst_ar_addr", ar_addr, 0);
      chk("mid_rst_rsp", m0_rsp_valid | m1_rsp_valid, 0);
      chk("mid_rst_rsp_data", m1_rsp_data, 0);
      tick();
      r_valid = 1'b0; r_last = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("post_rst_no_rsp", m0_rsp_valid | m1_rsp_valid, 0);
         chk("post_rst_idle", busy, 0);
      end
      run_vec(vecs[0]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
